// File: rtl/conv_agu_pkg.sv
// Shared types and constants for the convolution address generator (conv_agu).
package conv_agu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIdxRd,
        StLoad,
        StSweep,
        StDone
    } state_e;

    localparam logic [1:0]  MODE_CONV_FWD = 2'b00;
    localparam logic [1:0]  MODE_CONV_BWD = 2'b10;
    localparam int unsigned KERNEL_SIZE   = 3;
    localparam int unsigned ADDR_X_W      = 2;

    // Largest legal kernel tap index; anything above is a padding tap.
    localparam logic [7:0] KERNEL_MAX_IDX = 8'(KERNEL_SIZE * KERNEL_SIZE - 1);

endpackage

// File: rtl/conv_agu_coord.sv
// Combinational tap decode and coordinate/pad/address computation for conv_agu.
module conv_agu_coord
    import conv_agu_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [3:0] v,
    input  logic [7:0] t,
    input  logic       pad_u,
    input  logic       pad_l,
    input  logic [5:0] lim_r,
    input  logic [5:0] lim_d,
    output logic [7:0] addr,
    output logic       pad
);

    logic [7:0]        v_eff;
    logic [7:0]        kx;
    logic [7:0]        ky;
    logic signed [7:0] x;
    logic signed [7:0] y;

    always_comb begin
        case (mode)
            MODE_CONV_BWD: v_eff = 8'd8 - {4'd0, v};
            MODE_CONV_FWD: v_eff = {4'd0, v};
            default:       v_eff = {4'd0, v};
        endcase
        kx = v_eff % 8'(KERNEL_SIZE);
        ky = v_eff / 8'(KERNEL_SIZE);
    end

    // Column step is t[0], row step is t >> 1.
    always_comb begin
        x = $signed({7'd0, t[0]}) + $signed(kx) - $signed({7'd0, pad_l});
        y = $signed({1'b0, t[7:1]}) + $signed(ky) - $signed({7'd0, pad_u});
    end

    always_comb begin
        pad = x[7] || (x > $signed({2'b00, lim_d}))
           || y[7] || (y > $signed({2'b00, lim_r}))
           || ({4'd0, v} > KERNEL_MAX_IDX);
        addr = pad ? 8'd0 : {y[7-ADDR_X_W:0], x[ADDR_X_W-1:0]};
    end

endmodule

// File: rtl/conv_agu.sv
// Convolution address generator: walks idx-buffer taps and sweeps activation addresses.
// Optional CONV_AGU_STALL_EN adds a stall input that freezes the whole block.
module conv_agu
    import conv_agu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
`ifdef CONV_AGU_STALL_EN
    input  logic       stall,
`endif
    input  logic       start,
    input  logic [1:0] conf_mode,
    input  logic [7:0] conf_idx_cnt,
    input  logic [7:0] conf_trip_cnt,
    input  logic       conf_is_new,
    input  logic       conf_pad_u,
    input  logic       conf_pad_l,
    input  logic [5:0] conf_lim_r,
    input  logic [5:0] conf_lim_d,
    input  logic [5:0] conf_row_cnt,
    output logic       idx_rd_en,
    output logic [7:0] idx_rd_addr,
    input  logic [3:0] idx_rd_data,
    output logic       act_vld,
    output logic [7:0] act_addr,
    output logic       act_pad,
    output logic       acc_clr,
    output logic       idx_last,
    output logic       trip_last,
    output logic       busy,
    output logic       done
);

`ifndef CONV_AGU_STALL_EN
    logic stall;
    assign stall = 1'b0;
`endif

    state_e     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] t_q, t_d;
    logic [3:0] v_q;
    logic       rd_issued_q;

    logic [1:0] mode_q;
    logic [7:0] idx_cnt_q;
    logic [7:0] trip_q;
    logic       is_new_q;
    logic       pad_u_q;
    logic       pad_l_q;
    logic [5:0] lim_r_q;
    logic [5:0] lim_d_q;
    logic [5:0] row_cnt_q;

    logic       launch;
    logic       in_sweep;
    logic       last_idx;
    logic       last_trip;
    logic [7:0] coord_addr;
    logic       coord_pad;
    logic       unused_row_cnt;

    assign unused_row_cnt = ^row_cnt_q;

    assign launch    = (state_q == StIdle) && start;
    assign in_sweep  = (state_q == StSweep);
    assign last_idx  = (idx_q == idx_cnt_q - 8'd1);
    assign last_trip = (t_q == trip_q - 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= 8'd0;
            t_q         <= 8'd0;
            v_q         <= 4'd0;
            rd_issued_q <= 1'b0;
            mode_q      <= 2'd0;
            idx_cnt_q   <= 8'd0;
            trip_q      <= 8'd0;
            is_new_q    <= 1'b0;
            pad_u_q     <= 1'b0;
            pad_l_q     <= 1'b0;
            lim_r_q     <= 6'd0;
            lim_d_q     <= 6'd0;
            row_cnt_q   <= 6'd0;
        end else begin
            // Read data is only trusted if the preceding IDX_RD cycle really issued.
            rd_issued_q <= (state_q == StIdxRd) && !stall;
            if (!stall) begin
                state_q <= state_d;
                idx_q   <= idx_d;
                t_q     <= t_d;
            end
            if (launch && !stall) begin
                mode_q    <= conf_mode;
                idx_cnt_q <= conf_idx_cnt;
                trip_q    <= conf_trip_cnt;
                is_new_q  <= conf_is_new;
                pad_u_q   <= conf_pad_u;
                pad_l_q   <= conf_pad_l;
                lim_r_q   <= conf_lim_r;
                lim_d_q   <= conf_lim_d;
                row_cnt_q <= conf_row_cnt;
            end
            if ((state_q == StLoad) && rd_issued_q) begin
                v_q <= idx_rd_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        t_d     = t_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    idx_d   = 8'd0;
                    t_d     = 8'd0;
                    state_d = (conf_idx_cnt == 8'd0) ? StDone : StIdxRd;
                end
            end
            StIdxRd: state_d = StLoad;
            StLoad: begin
                t_d = 8'd0;
                if (trip_q != 8'd0) begin
                    state_d = StSweep;
                end else if (!last_idx) begin
                    idx_d   = idx_q + 8'd1;
                    state_d = StIdxRd;
                end else begin
                    state_d = StDone;
                end
            end
            StSweep: begin
                if (!last_trip) begin
                    t_d = t_q + 8'd1;
                end else begin
                    t_d = 8'd0;
                    if (!last_idx) begin
                        idx_d   = idx_q + 8'd1;
                        state_d = StIdxRd;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    conv_agu_coord u_coord (
        .mode  (mode_q),
        .v     (v_q),
        .t     (t_q),
        .pad_u (pad_u_q),
        .pad_l (pad_l_q),
        .lim_r (lim_r_q),
        .lim_d (lim_d_q),
        .addr  (coord_addr),
        .pad   (coord_pad)
    );

    // Under stall the address/flags hold their value; only the strobes drop.
    always_comb begin
        idx_rd_en   = (state_q == StIdxRd) && !stall;
        idx_rd_addr = (state_q == StIdxRd) ? idx_q : 8'd0;
        act_vld     = in_sweep && !stall;
        act_addr    = in_sweep ? coord_addr : 8'd0;
        act_pad     = in_sweep && coord_pad;
        acc_clr     = in_sweep && (t_q == 8'd0) && (idx_q == 8'd0) && is_new_q;
        idx_last    = in_sweep && last_idx;
        trip_last   = in_sweep && last_trip;
        busy        = (state_q != StIdle);
        done        = (state_q == StDone);
    end

endmodule

// File: tb/tb_conv_agu.sv
// Directed, table-driven bench for conv_agu (stall cases run when CONV_AGU_STALL_EN is defined).
module tb_conv_agu;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] conf_mode;
    logic [7:0] conf_idx_cnt;
    logic [7:0] conf_trip_cnt;
    logic       conf_is_new;
    logic       conf_pad_u;
    logic       conf_pad_l;
    logic [5:0] conf_lim_r;
    logic [5:0] conf_lim_d;
    logic [5:0] conf_row_cnt;
    logic       idx_rd_en;
    logic [7:0] idx_rd_addr;
    logic [3:0] idx_rd_data;
    logic       act_vld;
    logic [7:0] act_addr;
    logic       act_pad;
    logic       acc_clr;
    logic       idx_last;
    logic       trip_last;
    logic       busy;
    logic       done;
`ifdef CONV_AGU_STALL_EN
    logic       stall;
`endif

    int checks;
    int errors;

    logic [3:0] mem [3];

    typedef struct {
        logic [7:0]  idx_cnt;
        logic [7:0]  trip;
        logic [1:0]  mode;
        logic        is_new;
        logic        pad_u;
        logic        pad_l;
        logic [5:0]  lim_r;
        logic [5:0]  lim_d;
        logic [3:0]  d0;
        logic [3:0]  d1;
        logic [3:0]  d2;
        int          n_vld;
        int          n_rd;
        int          first_vld;
        int          done_cyc;
        logic [63:0] addr;
        logic [7:0]  pad_m;
        logic [7:0]  trip_m;
        logic [7:0]  idx_m;
        logic [7:0]  acc_m;
    } vec_t;

    vec_t tbl [8];

    conv_agu dut (
        .clk           (clk),
        .rst           (rst),
`ifdef CONV_AGU_STALL_EN
        .stall         (stall),
`endif
        .start         (start),
        .conf_mode     (conf_mode),
        .conf_idx_cnt  (conf_idx_cnt),
        .conf_trip_cnt (conf_trip_cnt),
        .conf_is_new   (conf_is_new),
        .conf_pad_u    (conf_pad_u),
        .conf_pad_l    (conf_pad_l),
        .conf_lim_r    (conf_lim_r),
        .conf_lim_d    (conf_lim_d),
        .conf_row_cnt  (conf_row_cnt),
        .idx_rd_en     (idx_rd_en),
        .idx_rd_addr   (idx_rd_addr),
        .idx_rd_data   (idx_rd_data),
        .act_vld       (act_vld),
        .act_addr      (act_addr),
        .act_pad       (act_pad),
        .acc_clr       (acc_clr),
        .idx_last      (idx_last),
        .trip_last     (trip_last),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Idx buffer: data one cycle after the read; garbage (pad tap 15) when no read issued.
    always @(posedge clk) begin
        if (idx_rd_en && (idx_rd_addr < 8'd3)) idx_rd_data <= mem[idx_rd_addr[1:0]];
        else                                   idx_rd_data <= 4'hf;
    end

    task automatic check(input string what, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", what, got, exp);
        end
    endtask

    task automatic run_case(input string name, input vec_t v, input int restart_at,
                            input int stall_at, input int stall_len, input logic [7:0] hold_addr);
        int          cyc;
        int          nvld;
        int          nrd;
        int          first;
        int          dcyc;
        int          zero_bad;
        int          busy_bad;
        logic        in_stall;
        logic [63:0] got_addr;
        logic [7:0]  pm, tm, im, am;
        mem[0] = v.d0;
        mem[1] = v.d1;
        mem[2] = v.d2;
        conf_mode     = v.mode;
        conf_idx_cnt  = v.idx_cnt;
        conf_trip_cnt = v.trip;
        conf_is_new   = v.is_new;
        conf_pad_u    = v.pad_u;
        conf_pad_l    = v.pad_l;
        conf_lim_r    = v.lim_r;
        conf_lim_d    = v.lim_d;
        conf_row_cnt  = 6'd1;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble config after launch: the run must use the latched copy.
        conf_mode     = 2'($urandom);
        conf_idx_cnt  = 8'($urandom);
        conf_trip_cnt = 8'($urandom);
        conf_is_new   = 1'($urandom);
        conf_pad_u    = 1'($urandom);
        conf_pad_l    = 1'($urandom);
        conf_lim_r    = 6'($urandom);
        conf_lim_d    = 6'($urandom);
        cyc = 1; nvld = 0; nrd = 0; first = -1; dcyc = -1; zero_bad = 0; busy_bad = 0;
        got_addr = '0; pm = '0; tm = '0; im = '0; am = '0;
        while (cyc <= 60 && dcyc < 0) begin
            in_stall = (stall_len > 0) && (cyc >= stall_at) && (cyc < stall_at + stall_len);
`ifdef CONV_AGU_STALL_EN
            stall = in_stall;
`endif
            start = (cyc == restart_at);
            #1;
            if (in_stall) begin
                check($sformatf("%s stall_strobes c%0d", name, cyc), {act_vld, idx_rd_en}, 2'b00);
                check($sformatf("%s stall_hold c%0d", name, cyc), act_addr, hold_addr);
            end
            if (act_vld) begin
                if (first < 0) first = cyc;
                if (nvld < 8) begin
                    got_addr[8*nvld +: 8] = act_addr;
                    pm[nvld] = act_pad;
                    tm[nvld] = trip_last;
                    im[nvld] = idx_last;
                    am[nvld] = acc_clr;
                end
                nvld++;
            end else if (!in_stall && (act_addr != 8'd0 || acc_clr || trip_last || idx_last)) begin
                zero_bad++;
            end
            if (idx_rd_en) nrd++;
            if (!busy) busy_bad++;
            if (done) dcyc = cyc;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
`ifdef CONV_AGU_STALL_EN
        stall = 1'b0;
`endif
        #1;
        check({name, " n_vld"}, nvld, v.n_vld);
        check({name, " n_rd"}, nrd, v.n_rd);
        check({name, " done_cyc"}, dcyc, v.done_cyc);
        if (v.n_vld > 0) check({name, " first_vld"}, first, v.first_vld);
        for (int i = 0; i < v.n_vld && i < 8; i++) begin
            check($sformatf("%s addr%0d", name, i), got_addr[8*i +: 8], v.addr[8*i +: 8]);
        end
        check({name, " pad_mask"}, pm, v.pad_m);
        check({name, " trip_last_mask"}, tm, v.trip_m);
        check({name, " idx_last_mask"}, im, v.idx_m);
        check({name, " acc_clr_mask"}, am, v.acc_m);
        check({name, " idle_outputs_clean"}, zero_bad, 0);
        check({name, " busy_while_run"}, busy_bad, 0);
        check({name, " idle_after_done"}, {busy, done}, 2'b00);
    endtask

    vec_t v;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0;
        conf_mode = '0; conf_idx_cnt = '0; conf_trip_cnt = '0; conf_is_new = 1'b0;
        conf_pad_u = 1'b0; conf_pad_l = 1'b0; conf_lim_r = '0; conf_lim_d = '0;
        conf_row_cnt = '0;
`ifdef CONV_AGU_STALL_EN
        stall = 1'b0;
`endif
        //            idx    trip   mode  new   pu    pl    lim_r lim_d d0    d1    d2
        //            nv nr fv dc addr               pad    trip   idx    acc
        tbl[0] = '{8'd1, 8'd4, 2'd0, 1'b0, 1'b0, 1'b0, 6'd5, 6'd3, 4'd4, 4'd0, 4'd0,
                   4, 1, 3, 7, 64'h0a09_0605, 8'h00, 8'h08, 8'h0f, 8'h00};
        tbl[1] = '{8'd1, 8'd4, 2'd0, 1'b0, 1'b1, 1'b1, 6'd5, 6'd3, 4'd0, 4'd0, 4'd0,
                   4, 1, 3, 7, 64'h0, 8'h07, 8'h08, 8'h0f, 8'h00};
        tbl[2] = '{8'd1, 8'd2, 2'd2, 1'b0, 1'b0, 1'b0, 6'd5, 6'd3, 4'd0, 4'd0, 4'd0,
                   2, 1, 3, 5, 64'h0b0a, 8'h00, 8'h02, 8'h03, 8'h00};
        tbl[3] = '{8'd0, 8'd4, 2'd0, 1'b1, 1'b0, 1'b0, 6'd5, 6'd3, 4'd4, 4'd0, 4'd0,
                   0, 0, 0, 1, 64'h0, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[4] = '{8'd3, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0, 6'd5, 6'd3, 4'd1, 4'd2, 4'd3,
                   0, 3, 0, 7, 64'h0, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[5] = '{8'd2, 8'd2, 2'd0, 1'b1, 1'b0, 1'b0, 6'd5, 6'd3, 4'd9, 4'd9, 4'd0,
                   4, 2, 3, 9, 64'h0, 8'h0f, 8'h0a, 8'h0c, 8'h01};
        tbl[6] = '{8'd2, 8'd2, 2'd0, 1'b0, 1'b0, 1'b0, 6'd5, 6'd3, 4'd1, 4'd5, 4'd0,
                   4, 2, 3, 9, 64'h0706_0201, 8'h00, 8'h0a, 8'h0c, 8'h00};
        tbl[7] = '{8'd1, 8'd4, 2'd2, 1'b1, 1'b0, 1'b0, 6'd0, 6'd2, 4'd6, 4'd0, 4'd0,
                   4, 1, 3, 7, 64'h02, 8'h0e, 8'h08, 8'h0f, 8'h01};

        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {idx_rd_en, idx_rd_addr, act_vld, act_addr, act_pad, acc_clr,
                                idx_last, trip_last, busy, done}, '0);
        // First start lands in the very first cycle with rst low.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_case($sformatf("vec%0d", i), tbl[i], 0, 0, 0, 8'd0);
            @(negedge clk);
        end

        run_case("busy_restart", tbl[0], 2, 0, 0, 8'd0);
        @(negedge clk);

        // Reset during the second SWEEP cycle.
        mem[0] = 4'd4;
        conf_idx_cnt = 8'd1; conf_trip_cnt = 8'd4; conf_mode = 2'd0; conf_is_new = 1'b1;
        conf_pad_u = 1'b0; conf_pad_l = 1'b0; conf_lim_r = 6'd5; conf_lim_d = 6'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("pre_reset_addr", {act_vld, act_addr}, {1'b1, 8'd6});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midop_reset_outputs", {idx_rd_en, idx_rd_addr, act_vld, act_addr, act_pad,
                                      acc_clr, idx_last, trip_last, busy, done}, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("no_done_after_reset c%0d", i), {busy, done}, 2'b00);
        end
        @(negedge clk);

`ifdef CONV_AGU_STALL_EN
        v = tbl[0];
        v.done_cyc = 9;
        run_case("stall_sweep", v, 0, 4, 2, 8'd6);
        @(negedge clk);
        v = tbl[6];
        v.first_vld = 4;
        v.done_cyc = 10;
        run_case("stall_idx_rd", v, 0, 1, 1, 8'd0);
        @(negedge clk);
`else
        v = tbl[0];
        run_case("repeat_vec0", v, 0, 0, 0, 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
